// File: rtl/fpu_arbiter_if.sv
// Client and fpu_top side signals of fpu_arbiter. The slave modport is the arbiter's view.
// With FPU_ARB_PRIO_EN defined, a per-requester priority input is added.
interface fpu_arbiter_if #(
   parameter int BIT_WIDTH = 128,
   parameter int NUM_REQ   = 2
);
   logic [NUM_REQ-1:0]           i_req_valid;
   logic [NUM_REQ-1:0]           o_req_ready;
   logic [3*NUM_REQ-1:0]         i_req_mode;
   logic [2*NUM_REQ-1:0]         i_req_op;
   logic [BIT_WIDTH*NUM_REQ-1:0] i_req_a;
   logic [BIT_WIDTH*NUM_REQ-1:0] i_req_b;
`ifdef FPU_ARB_PRIO_EN
   logic [NUM_REQ-1:0]           i_req_prio;
`endif
   logic [NUM_REQ-1:0]           o_rsp_valid;
   logic [NUM_REQ-1:0]           i_rsp_ready;
   logic [BIT_WIDTH-1:0]         o_rsp_data;
   logic [4:0]                   o_rsp_exc;
   logic                         o_fpu_valid;
   logic [2:0]                   o_fpu_mode;
   logic [1:0]                   o_fpu_op;
   logic [BIT_WIDTH-1:0]         o_fpu_a;
   logic [BIT_WIDTH-1:0]         o_fpu_b;
   logic [BIT_WIDTH-1:0]         i_fpu_out;
   logic [4:0]                   i_fpu_exc;
   logic                         o_busy;

   modport slave (
`ifdef FPU_ARB_PRIO_EN
      input  i_req_prio,
`endif
      input  i_req_valid, i_req_mode, i_req_op, i_req_a, i_req_b, i_rsp_ready,
      input  i_fpu_out, i_fpu_exc,
      output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_exc,
      output o_fpu_valid, o_fpu_mode, o_fpu_op, o_fpu_a, o_fpu_b, o_busy
   );

   modport master (
`ifdef FPU_ARB_PRIO_EN
      output i_req_prio,
`endif
      output i_req_valid, i_req_mode, i_req_op, i_req_a, i_req_b, i_rsp_ready,
      output i_fpu_out, i_fpu_exc,
      input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_exc,
      input  o_fpu_valid, o_fpu_mode, o_fpu_op, o_fpu_a, o_fpu_b, o_busy
   );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fpu_top among NUM_REQ requesters, one op in flight.
// Optional FPU_ARB_PRIO_EN: prio=1 requests win over prio=0, round-robin within each class.
module fpu_arbiter #(
   parameter int BIT_WIDTH   = 128,
   parameter int NUM_REQ     = 2,
   parameter int FPU_LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   fpu_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
   localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

   typedef struct packed {
      logic [2:0]           mode;
      logic [1:0]           op;
      logic [BIT_WIDTH-1:0] a;
      logic [BIT_WIDTH-1:0] b;
   } issue_t;

   logic [1:0]           state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [PW-1:0]        gnt_q, gnt_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   issue_t               iss_q, iss_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [BIT_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [4:0]           rsp_exc_q, rsp_exc_d;

   logic [NUM_REQ-1:0]   cand;
   logic [NUM_REQ-1:0]   req_ready;
   logic [PW-1:0]        sel;
   logic                 sel_ok;
   logic [PW:0]          idx;

   // Scan from the farthest offset down so the last hit is the one nearest the pointer.
   always_comb begin
      cand = bus.i_req_valid;
`ifdef FPU_ARB_PRIO_EN
      if (|(bus.i_req_valid & bus.i_req_prio))
         cand = bus.i_req_valid & bus.i_req_prio;
`endif
      sel    = ptr_q;
      sel_ok = 1'b0;
      idx    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, ptr_q} + (PW+1)'(k);
         if (idx >= (PW+1)'(NUM_REQ))
            idx = idx - (PW+1)'(NUM_REQ);
         if (cand[idx[PW-1:0]]) begin
            sel    = idx[PW-1:0];
            sel_ok = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      iss_d       = iss_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_exc_d   = rsp_exc_q;
      req_ready   = '0;
      case (state_q)
         S_IDLE: begin
            if (sel_ok) begin
               req_ready[sel] = 1'b1;
               gnt_d          = sel;
               iss_d.mode     = bus.i_req_mode[sel*3 +: 3];
               iss_d.op       = bus.i_req_op[sel*2 +: 2];
               iss_d.a        = bus.i_req_a[sel*BIT_WIDTH +: BIT_WIDTH];
               iss_d.b        = bus.i_req_b[sel*BIT_WIDTH +: BIT_WIDTH];
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CW'(FPU_LATENCY - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               rsp_data_d         = bus.i_fpu_out;
               rsp_exc_d          = bus.i_fpu_exc;
               rsp_valid_d[gnt_q] = 1'b1;
               state_d            = S_RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RESP: begin
            // Only the granted requester's ready matters; others are ignored.
            if (bus.i_rsp_ready[gnt_q]) begin
               rsp_valid_d = '0;
               ptr_d       = (gnt_q == LAST) ? '0 : gnt_q + PW'(1);
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         cnt_q       <= '0;
         iss_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_exc_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         iss_q       <= iss_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_exc_q   <= rsp_exc_d;
      end
   end

   assign bus.o_req_ready = req_ready;
   assign bus.o_rsp_valid = rsp_valid_q;
   assign bus.o_rsp_data  = rsp_data_q;
   assign bus.o_rsp_exc   = rsp_exc_q;
   assign bus.o_fpu_valid = (state_q == S_ISSUE);
   assign bus.o_fpu_mode  = iss_q.mode;
   assign bus.o_fpu_op    = iss_q.op;
   assign bus.o_fpu_a     = iss_q.a;
   assign bus.o_fpu_b     = iss_q.b;
   assign bus.o_busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter with a behavioural fpu_top stand-in and a
// transaction-level arbitration model (grant order, latency, response routing).
module tb_fpu_arbiter;
   localparam int BW  = 32;
   localparam int NR  = 2;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fpu_arbiter_if #(.BIT_WIDTH(BW), .NUM_REQ(NR)) bus ();
   fpu_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR), .FPU_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct { int r; logic [BW-1:0] data; logic [4:0] exc; } exp_t;
   exp_t exp_q[$];
   int   acc_log[$];
   int   tests = 0;
   int   fails = 0;

   // fpu_top stand-in: two IEEE cases are exact, everything else is a fixed scramble.
   function automatic logic [BW+4:0] fpu_ref(logic [2:0] m, logic [1:0] op,
                                             logic [BW-1:0] a, logic [BW-1:0] b);
      if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 5'b00000};
      if (op == 2'b11 && a == 32'h3F800000 && b == 32'h00000000) return {32'h7F800000, 5'b00100};
      return {(a * 32'd3) ^ {b[15:0], b[31:16]} ^ {27'd0, m, op}, a[4:0] ^ b[9:5] ^ {op, m}};
   endfunction

   function automatic int exp_grant(logic [NR-1:0] v, logic [NR-1:0] p, int pt);
      logic [NR-1:0] c;
      c = ((v & p) != '0) ? (v & p) : v;
      for (int k = 0; k < NR; k++)
         if (c[(pt + k) % NR]) return (pt + k) % NR;
      return -1;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // fpu_top model: result valid exactly LAT cycles after i_valid, junk otherwise.
   logic [BW+4:0]  pipe [LAT];
   logic [LAT-1:0] pv = '0;
   logic [BW+4:0]  junk = '0;
   always @(posedge clk) begin
      pipe[0] <= fpu_ref(bus.o_fpu_mode, bus.o_fpu_op, bus.o_fpu_a, bus.o_fpu_b);
      pv[0]   <= bus.o_fpu_valid;
      for (int i = 1; i < LAT; i++) begin
         pipe[i] <= pipe[i-1];
         pv[i]   <= pv[i-1];
      end
      junk <= {$urandom, 5'($urandom)};
   end
   assign bus.i_fpu_out = pv[LAT-1] ? pipe[LAT-1][BW+4:5] : junk[BW+4:5];
   assign bus.i_fpu_exc = pv[LAT-1] ? pipe[LAT-1][4:0]    : junk[4:0];

   // Monitor: transaction model of the arbiter, checked every cycle.
   int            cyc = 0, gcyc = 0, g = 0, ptr = 0, eg;
   bit            in_flight = 1'b0;
   logic [NR-1:0] exp_rdy, exp_rv, prio_v;
   logic [2:0]    c_mode;
   logic [1:0]    c_op;
   logic [BW-1:0] c_a, c_b;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_flight = 1'b0;
         ptr       = 0;
         exp_q.delete();
      end else begin
         cyc++;
`ifdef FPU_ARB_PRIO_EN
         prio_v = bus.i_req_prio;
`else
         prio_v = '0;
`endif
         eg      = -1;
         exp_rdy = '0;
         if (!in_flight) begin
            eg = exp_grant(bus.i_req_valid, prio_v, ptr);
            if (eg >= 0) exp_rdy[eg] = 1'b1;
         end
         chk("req_ready", 64'(bus.o_req_ready), 64'(exp_rdy));
         chk("busy", 64'(bus.o_busy), 64'(in_flight));
         chk("fpu_valid", 64'(bus.o_fpu_valid), 64'(in_flight && cyc == gcyc + 1));
         if (in_flight && cyc == gcyc + 1) begin
            chk("fpu_a", 64'(bus.o_fpu_a), 64'(c_a));
            chk("fpu_b", 64'(bus.o_fpu_b), 64'(c_b));
            chk("fpu_mode_op", 64'({bus.o_fpu_mode, bus.o_fpu_op}), 64'({c_mode, c_op}));
         end
         exp_rv = '0;
         if (in_flight && cyc - gcyc >= LAT + 2) exp_rv[g] = 1'b1;
         chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(exp_rv));
         if (exp_rv != '0) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rsp_scoreboard: response for req %0d with empty queue", g);
            end else begin
               chk("rsp_req", 64'(g), 64'(exp_q[0].r));
               chk("rsp_data", 64'(bus.o_rsp_data), 64'(exp_q[0].data));
               chk("rsp_exc", 64'(bus.o_rsp_exc), 64'(exp_q[0].exc));
               if (bus.i_rsp_ready[g]) begin
                  void'(exp_q.pop_front());
                  in_flight = 1'b0;
                  ptr       = (g + 1) % NR;
               end
            end
         end
         if (eg >= 0) begin
            in_flight = 1'b1;
            g         = eg;
            gcyc      = cyc;
            c_mode    = bus.i_req_mode[3*eg +: 3];
            c_op      = bus.i_req_op[2*eg +: 2];
            c_a       = bus.i_req_a[BW*eg +: BW];
            c_b       = bus.i_req_b[BW*eg +: BW];
         end
      end
   end

   // Driver: snapshots taken at the negedge, inputs changed 1 time unit after posedge.
   logic [NR-1:0] acc, s_rsp_valid, s_req_ready;
   logic          s_busy;
   logic [BW-1:0] s_data, last_data, hold_d;
   logic [4:0]    s_exc, last_exc, hold_e;

   task automatic step();
      logic [BW+4:0] res;
      @(negedge clk);
      s_rsp_valid = bus.o_rsp_valid;
      s_req_ready = bus.o_req_ready;
      s_busy      = bus.o_busy;
      s_data      = bus.o_rsp_data;
      s_exc       = bus.o_rsp_exc;
      if (s_rsp_valid != '0) begin
         last_data = s_data;
         last_exc  = s_exc;
      end
      acc = '0;
      if (rst_n)
         for (int r = 0; r < NR; r++)
            if (bus.o_req_ready[r] && bus.i_req_valid[r]) begin
               res = fpu_ref(bus.i_req_mode[3*r +: 3], bus.i_req_op[2*r +: 2],
                             bus.i_req_a[BW*r +: BW], bus.i_req_b[BW*r +: BW]);
               exp_q.push_back('{r, res[BW+4:5], res[4:0]});
               acc[r] = 1'b1;
               acc_log.push_back(r);
            end
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(int r, logic v, logic [2:0] m, logic [1:0] op,
                          logic [BW-1:0] a, logic [BW-1:0] b);
      bus.i_req_valid[r]     = v;
      bus.i_req_mode[3*r +: 3] = m;
      bus.i_req_op[2*r +: 2]   = op;
      bus.i_req_a[BW*r +: BW]  = a;
      bus.i_req_b[BW*r +: BW]  = b;
   endtask

   task automatic set_rand(int r, logic v);
      set_req(r, v, 3'($urandom), 2'($urandom), $urandom, $urandom);
   endtask

   task automatic issue(int r, logic [2:0] m, logic [1:0] op, logic [BW-1:0] a, logic [BW-1:0] b);
      set_req(r, 1'b1, m, op, a, b);
      acc = '0;
      for (int i = 0; i < 40 && !acc[r]; i++) step();
      chk("grant_wait", 64'(acc[r]), 64'd1);
      bus.i_req_valid[r] = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         step();
         if (!s_busy && exp_q.size() == 0) break;
      end
      chk("drain", 64'({s_busy, exp_q.size() == 0}), 64'b01);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_req_ready"}, 64'(bus.o_req_ready), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(bus.o_rsp_valid), 64'd0);
      chk({tag, "_rsp_data"}, 64'(bus.o_rsp_data), 64'd0);
      chk({tag, "_rsp_exc"}, 64'(bus.o_rsp_exc), 64'd0);
      chk({tag, "_fpu_valid"}, 64'(bus.o_fpu_valid), 64'd0);
      chk({tag, "_fpu_ab"}, {bus.o_fpu_a, bus.o_fpu_b}, 64'd0);
      chk({tag, "_fpu_mode_op"}, 64'({bus.o_fpu_mode, bus.o_fpu_op}), 64'd0);
      chk({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.i_req_valid = '0;
      bus.i_req_mode  = '0;
      bus.i_req_op    = '0;
      bus.i_req_a     = '0;
      bus.i_req_b     = '0;
      bus.i_rsp_ready = '1;
`ifdef FPU_ARB_PRIO_EN
      bus.i_req_prio  = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      // Single ADD 1.0 + 2.0 from requester 0.
      issue(0, 3'd0, 2'b00, 32'h3F800000, 32'h40000000);
      wait_idle();
      chk("add_data", 64'(last_data), 64'h40400000);
      chk("add_exc", 64'(last_exc), 64'd0);

      // DIV 1.0 / 0.0 from requester 1: divide-by-zero flag, +inf result.
      issue(1, 3'd0, 2'b11, 32'h3F800000, 32'h00000000);
      wait_idle();
      chk("div_data", 64'(last_data), 64'h7F800000);
      chk("div_exc_dz", 64'(last_exc[2]), 64'd1);

      // Fairness: both held valid for four grants.
      acc_log.delete();
      set_rand(0, 1'b1);
      set_rand(1, 1'b1);
      for (int i = 0; i < 80 && acc_log.size() < 4; i++) begin
         step();
         for (int r = 0; r < NR; r++) if (acc[r]) set_rand(r, 1'b1);
      end
      bus.i_req_valid = '0;
      wait_idle();
      chk("fair_count", 64'(acc_log.size()), 64'd4);
      for (int k = 0; k < acc_log.size() && k < 4; k++)
         chk("fair_order", 64'(acc_log[k]), 64'(k % 2));

      // Backpressure on requester 1 while requester 0 waits.
      bus.i_rsp_ready[1] = 1'b0;
      issue(1, 3'($urandom), 2'($urandom), $urandom, $urandom);
      set_rand(0, 1'b1);
      for (int i = 0; i < 40 && !s_rsp_valid[1]; i++) step();
      chk("bp_rsp_seen", 64'(s_rsp_valid[1]), 64'd1);
      hold_d = s_data;
      hold_e = s_exc;
      repeat (10) begin
         step();
         chk("bp_data_stable", 64'(s_data), 64'(hold_d));
         chk("bp_exc_stable", 64'(s_exc), 64'(hold_e));
         chk("bp_no_grant", 64'(s_req_ready), 64'd0);
      end
      bus.i_rsp_ready[1] = 1'b1;
      acc = '0;
      for (int i = 0; i < 20 && !acc[0]; i++) step();
      chk("bp_next_grant", 64'(acc[0]), 64'd1);
      bus.i_req_valid = '0;
      wait_idle();

      // Randomised traffic, including dropped requests and random response readiness.
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < NR; r++) begin
            if (acc[r] || !bus.i_req_valid[r]) set_rand(r, $urandom_range(0, 3) != 0);
            else if ($urandom_range(0, 9) == 0) bus.i_req_valid[r] = 1'b0;
            bus.i_rsp_ready[r] = $urandom_range(0, 3) != 0;
         end
`ifdef FPU_ARB_PRIO_EN
         bus.i_req_prio = NR'($urandom);
`endif
         step();
      end
      bus.i_req_valid = '0;
      bus.i_rsp_ready = '1;
`ifdef FPU_ARB_PRIO_EN
      bus.i_req_prio  = '0;
`endif
      wait_idle();

      // Reset while the operation is in WAIT: everything clears, no response follows.
      issue(0, 3'($urandom), 2'($urandom), $urandom, $urandom);
      step();
      rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      step();
      step();
      rst_n = 1'b1;
      repeat (LAT + 4) step();
      chk("rst_no_rsp", 64'(s_rsp_valid), 64'd0);
      chk("rst_idle", 64'(s_busy), 64'd0);

`ifdef FPU_ARB_PRIO_EN
      // Priority request beats the round-robin pointer (which is 0 after reset).
      bus.i_req_prio = 2'b10;
      set_rand(0, 1'b1);
      set_rand(1, 1'b1);
      acc = '0;
      for (int i = 0; i < 20 && acc == '0; i++) step();
      chk("prio_first", 64'(acc), 64'b10);
      bus.i_req_valid = '0;
      bus.i_req_prio  = '0;
      wait_idle();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
